// File: rtl/pf_pkg.sv
// Shared constants, FSM encodings and ROM address helper for the playfield tile fetcher.
package pf_pkg;

    localparam int PF_TILES  = 32;
    localparam int PF_RAM_AW = 10;
    localparam int TILE_W    = 8;
    localparam int ROM_AW    = 11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ROM   = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_FULL  = 3'd4;

    // Flipped screens read each tile upside down, so the row inside the tile is inverted.
    function automatic logic [ROM_AW-1:0] rom_addr(input logic [7:0] code,
                                                   input logic [2:0] row3,
                                                   input logic       flip);
        return {code, (flip ? ~row3 : row3)};
    endfunction

endpackage

// File: rtl/pf_fetch_if.sv
// Memory-side bus of the fetcher: playfield RAM handshake plus the shared pattern ROM pair.
interface pf_fetch_if #(
    parameter int RAM_AW = 10
);
    import pf_pkg::*;

    logic              ram_req;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_ack;
    logic [7:0]        ram_data;
    logic [ROM_AW-1:0] rom_a;
    logic [7:0]        rom0_d;
    logic [7:0]        rom1_d;

    modport master (output ram_req, ram_addr, rom_a,
                    input  ram_ack, ram_data, rom0_d, rom1_d);

    modport slave  (input  ram_req, ram_addr, rom_a,
                    output ram_ack, ram_data, rom0_d, rom1_d);

endinterface

// File: rtl/pf_shift.sv
// Two-plane 8-pixel shifter; when empty it presents the buffer head so a load can emit at once.
module pf_shift
    import pf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              flip,
    input  logic              adv,
    input  logic              load,
    input  logic [TILE_W-1:0] d0,
    input  logic [TILE_W-1:0] d1,
    output logic [1:0]        pix_o,
    output logic              empty,
    output logic              last
);

    logic [TILE_W-1:0] p0_q, p0_d, p1_q, p1_d;
    logic [TILE_W-1:0] src0, src1;
    logic [3:0]        cnt_q, cnt_d;

    assign empty = (cnt_q == 4'd0);
    assign last  = (cnt_q == 4'd1);
    assign src0  = empty ? d0 : p0_q;
    assign src1  = empty ? d1 : p1_q;
    assign pix_o = flip ? {src1[0], src0[0]} : {src1[TILE_W-1], src0[TILE_W-1]};

    always_comb begin
        p0_d  = p0_q;
        p1_d  = p1_q;
        cnt_d = cnt_q;
        if (clear) begin
            p0_d  = '0;
            p1_d  = '0;
            cnt_d = '0;
        end else if (adv && load && !empty) begin
            p0_d  = d0;
            p1_d  = d1;
            cnt_d = 4'(TILE_W);
        end else if (adv && (load || !empty)) begin
            p0_d  = flip ? (src0 >> 1) : (src0 << 1);
            p1_d  = flip ? (src1 >> 1) : (src1 << 1);
            cnt_d = empty ? 4'(TILE_W - 1) : cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_q  <= '0;
            p1_q  <= '0;
            cnt_q <= '0;
        end else begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pf_fetch.sv
// Playfield tile fetcher: reads tile codes, addresses the pattern ROMs and serialises 2-bit pixels.
module pf_fetch
    import pf_pkg::*;
#(
    parameter int TILES  = PF_TILES,
    parameter int RAM_AW = PF_RAM_AW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       line_start,
    input  logic [7:0] vrow,
    input  logic       flip,
    pf_fetch_if.master bus,
    output logic [1:0] pix,
    output logic       pix_valid,
    output logic       line_done,
    output logic       underrun
);

    localparam int COL_W = $clog2(TILES);
    localparam int TO_W  = $clog2(TILES + 1);

    function automatic logic [RAM_AW-1:0] tile_addr(input logic [7:0]       v,
                                                    input logic             f,
                                                    input logic [COL_W-1:0] c);
        return RAM_AW'({(f ? ~v[7:3] : v[7:3]), (f ? ~c : c)});
    endfunction

    logic [2:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              last_q, last_d, restart_q, restart_d;
    logic [7:0]        vrow_q, vrow_d;
    logic              flip_q, flip_d;
    logic              ram_req_q, ram_req_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [ROM_AW-1:0] rom_a_q, rom_a_d;
    logic [7:0]        buf0_q, buf0_d, buf1_q, buf1_d;
    logic [TO_W-1:0]   tiles_out_q, tiles_out_d;
    logic              active_q, active_d;
    logic [1:0]        pix_q, pix_d;
    logic              pix_valid_q, pix_valid_d, line_done_q, line_done_d, underrun_q, underrun_d;
    logic              buf_full, sh_adv, sh_load, sh_empty, sh_last;
    logic [1:0]        sh_pix;

    assign buf_full = (state_q == S_FULL);
    assign sh_adv   = pix_ce && active_q && !line_start;
    assign sh_load  = sh_adv && buf_full && (sh_empty || sh_last);

    pf_shift u_shift (
        .clk   (clk),
        .reset (reset),
        .clear (line_start),
        .flip  (flip_q),
        .adv   (sh_adv),
        .load  (sh_load),
        .d0    (buf0_q),
        .d1    (buf1_q),
        .pix_o (sh_pix),
        .empty (sh_empty),
        .last  (sh_last)
    );

    // A line_start while a request is outstanding cannot drop it; the ack is swallowed and column 0 re-requested.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        last_d     = last_q;
        restart_d  = restart_q;
        vrow_d     = vrow_q;
        flip_d     = flip_q;
        ram_req_d  = ram_req_q;
        ram_addr_d = ram_addr_q;
        rom_a_d    = rom_a_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (line_start) begin
            vrow_d = vrow;
            flip_d = flip;
            col_d  = '0;
            last_d = 1'b0;
        end
        if (line_start && state_q != S_REQ) begin
            state_d    = S_REQ;
            ram_req_d  = 1'b1;
            ram_addr_d = tile_addr(vrow, flip, '0);
            restart_d  = 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.ram_ack) begin
                        if (restart_q || line_start) begin
                            ram_addr_d = tile_addr(vrow_d, flip_d, '0);
                            restart_d  = 1'b0;
                        end else begin
                            ram_req_d = 1'b0;
                            rom_a_d   = rom_addr(bus.ram_data, vrow_q[2:0], flip_q);
                            state_d   = S_ROM;
                        end
                    end else if (line_start) begin
                        restart_d = 1'b1;
                    end
                end
                S_ROM:   state_d = S_LATCH;
                S_LATCH: begin
                    buf0_d  = bus.rom0_d;
                    buf1_d  = bus.rom1_d;
                    col_d   = col_q + COL_W'(1);
                    last_d  = (col_q == COL_W'(TILES - 1));
                    state_d = S_FULL;
                end
                S_FULL: begin
                    if (sh_load) begin
                        if (last_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d    = S_REQ;
                            ram_req_d  = 1'b1;
                            ram_addr_d = tile_addr(vrow_q, flip_q, col_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Each pix_ce either emits a pixel, flags an underrun, or closes the line once every tile is out.
    always_comb begin
        pix_d       = pix_q;
        pix_valid_d = pix_valid_q;
        line_done_d = 1'b0;
        underrun_d  = underrun_q;
        tiles_out_d = tiles_out_q;
        active_d    = active_q;
        if (line_start) begin
            pix_d       = '0;
            pix_valid_d = 1'b0;
            underrun_d  = 1'b0;
            tiles_out_d = '0;
            active_d    = 1'b1;
        end else if (sh_adv) begin
            if (!sh_empty || buf_full) begin
                pix_d       = sh_pix;
                pix_valid_d = 1'b1;
                if (sh_load) tiles_out_d = tiles_out_q + TO_W'(1);
            end else if (tiles_out_q < TO_W'(TILES)) begin
                pix_d       = '0;
                pix_valid_d = 1'b0;
                underrun_d  = 1'b1;
            end else begin
                pix_d       = '0;
                pix_valid_d = 1'b0;
                line_done_d = 1'b1;
                active_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            last_q      <= 1'b0;
            restart_q   <= 1'b0;
            vrow_q      <= '0;
            flip_q      <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= '0;
            rom_a_q     <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            tiles_out_q <= '0;
            active_q    <= 1'b0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            last_q      <= last_d;
            restart_q   <= restart_d;
            vrow_q      <= vrow_d;
            flip_q      <= flip_d;
            ram_req_q   <= ram_req_d;
            ram_addr_q  <= ram_addr_d;
            rom_a_q     <= rom_a_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            tiles_out_q <= tiles_out_d;
            active_q    <= active_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            line_done_q <= line_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.ram_req  = ram_req_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.rom_a    = rom_a_q;
    assign pix          = pix_q;
    assign pix_valid    = pix_valid_q;
    assign line_done    = line_done_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_pf_fetch.sv
// Directed bench for pf_fetch: latency, flip ordering, ack stalls, underrun, full line and restarts.
module tb_pf_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce, line_start, flip;
    logic [7:0] vrow;
    logic [1:0] pix;
    logic       pix_valid, line_done, underrun;
    logic       auto_ack, man_ack;
    logic [7:0] ram_data_v, rom0_v, rom1_v;
    int         vectors = 0;
    int         miscompares = 0;

    pf_fetch_if #(.RAM_AW(10)) bus ();

    assign bus.ram_ack  = (auto_ack & bus.ram_req) | man_ack;
    assign bus.ram_data = ram_data_v;
    assign bus.rom0_d   = rom0_v;
    assign bus.rom1_d   = rom1_v;

    pf_fetch #(.TILES(32), .RAM_AW(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .line_start (line_start),
        .vrow       (vrow),
        .flip       (flip),
        .bus        (bus),
        .pix        (pix),
        .pix_valid  (pix_valid),
        .line_done  (line_done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pulses line_start for the current cycle (cycle 0) and returns one cycle later (cycle 1).
    task automatic apply_stimulus(input logic [7:0] v, input logic f);
        vrow       = v;
        flip       = f;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic settle();
        auto_ack   = 1'b1;
        man_ack    = 1'b0;
        pix_ce     = 1'b0;
        line_start = 1'b0;
        repeat (6) tick();
    endtask

    logic [1:0] exp_a [8] = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0] exp_b [8] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};

    initial begin
        int valid_cnt, hs_cnt, done_cnt, done_idx, last_valid_idx, addr_err;

        reset      = 1'b0;
        pix_ce     = 1'b0;
        line_start = 1'b0;
        vrow       = 8'h00;
        flip       = 1'b0;
        auto_ack   = 1'b0;
        man_ack    = 1'b0;
        ram_data_v = 8'h00;
        rom0_v     = 8'h00;
        rom1_v     = 8'h00;
        #2;
        check_output("reset ram_req", 16'(bus.ram_req), 16'h0);
        check_output("reset ram_addr", 16'(bus.ram_addr), 16'h0);
        check_output("reset rom_a", 16'(bus.rom_a), 16'h0);
        check_output("reset pix", 16'(pix), 16'h0);
        check_output("reset pix_valid", 16'(pix_valid), 16'h0);
        check_output("reset line_done", 16'(line_done), 16'h0);
        check_output("reset underrun", 16'(underrun), 16'h0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();

        $display("[TB] latency and MSB-first ordering");
        ram_data_v = 8'h41;
        rom0_v     = 8'hF0;
        rom1_v     = 8'hCC;
        auto_ack   = 1'b1;
        apply_stimulus(8'h45, 1'b0);
        check_output("A c1 ram_req", 16'(bus.ram_req), 16'h1);
        check_output("A c1 ram_addr", 16'(bus.ram_addr), 16'h100);
        tick();
        check_output("A c2 rom_a", 16'(bus.rom_a), 16'h20D);
        check_output("A c2 ram_req", 16'(bus.ram_req), 16'h0);
        tick();
        tick();
        check_output("A c4 pix_valid", 16'(pix_valid), 16'h0);
        pix_ce = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output($sformatf("A pix%0d", i), 16'(pix), 16'(exp_a[i]));
            check_output($sformatf("A valid%0d", i), 16'(pix_valid), 16'h1);
            if (i == 0) check_output("A tile1 ram_addr", 16'(bus.ram_addr), 16'h101);
            if (i == 7) check_output("A tile2 ram_addr", 16'(bus.ram_addr), 16'h102);
        end
        pix_ce = 1'b0;
        check_output("A underrun", 16'(underrun), 16'h0);
        settle();

        $display("[TB] flipped line");
        apply_stimulus(8'h45, 1'b1);
        check_output("B c1 ram_addr", 16'(bus.ram_addr), 16'h2FF);
        check_output("B c1 pix_valid", 16'(pix_valid), 16'h0);
        tick();
        check_output("B c2 rom_a", 16'(bus.rom_a), 16'h20A);
        tick();
        tick();
        pix_ce = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output($sformatf("B pix%0d", i), 16'(pix), 16'(exp_b[i]));
            if (i == 0) check_output("B tile1 ram_addr", 16'(bus.ram_addr), 16'h2FE);
        end
        pix_ce = 1'b0;
        settle();

        $display("[TB] ack delayed three cycles");
        auto_ack   = 1'b0;
        ram_data_v = 8'h7E;
        apply_stimulus(8'h45, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check_output($sformatf("C c%0d ram_req", i), 16'(bus.ram_req), 16'h1);
            check_output($sformatf("C c%0d ram_addr", i), 16'(bus.ram_addr), 16'h100);
            check_output($sformatf("C c%0d rom_a", i), 16'(bus.rom_a), 16'h20A);
            check_output($sformatf("C c%0d pix_valid", i), 16'(pix_valid), 16'h0);
            if (i == 4) man_ack = 1'b1;
            tick();
        end
        man_ack = 1'b0;
        check_output("C c5 rom_a", 16'(bus.rom_a), 16'h3F5);
        check_output("C c5 ram_req", 16'(bus.ram_req), 16'h0);
        tick();
        tick();
        pix_ce = 1'b1;
        tick();
        check_output("C first pix", 16'(pix), 16'h3);
        check_output("C first valid", 16'(pix_valid), 16'h1);
        pix_ce = 1'b0;
        settle();

        $display("[TB] underrun at line start");
        apply_stimulus(8'h45, 1'b0);
        check_output("D c1 underrun", 16'(underrun), 16'h0);
        pix_ce = 1'b1;
        tick();
        check_output("D c2 underrun", 16'(underrun), 16'h1);
        check_output("D c2 pix_valid", 16'(pix_valid), 16'h0);
        tick();
        tick();
        check_output("D c4 pix_valid", 16'(pix_valid), 16'h0);
        tick();
        check_output("D c5 pix_valid", 16'(pix_valid), 16'h1);
        check_output("D c5 underrun sticky", 16'(underrun), 16'h1);
        pix_ce     = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check_output("D underrun cleared", 16'(underrun), 16'h0);
        settle();

        $display("[TB] full line");
        apply_stimulus(8'h45, 1'b0);
        pix_ce         = 1'b1;
        valid_cnt      = 0;
        hs_cnt         = 0;
        done_cnt       = 0;
        done_idx       = 0;
        last_valid_idx = 0;
        addr_err       = 0;
        for (int i = 0; i < 400; i++) begin
            if (pix_valid) begin
                valid_cnt++;
                last_valid_idx = i;
            end
            if (line_done) begin
                done_cnt++;
                done_idx = i;
            end
            if (bus.ram_req && bus.ram_ack) begin
                if (bus.ram_addr != 10'(32'h100 + hs_cnt)) addr_err++;
                hs_cnt++;
            end
            tick();
        end
        pix_ce = 1'b0;
        check_output("E pix_valid count", 16'(valid_cnt), 16'd256);
        check_output("E handshakes", 16'(hs_cnt), 16'd32);
        check_output("E address errors", 16'(addr_err), 16'd0);
        check_output("E line_done pulses", 16'(done_cnt), 16'd1);
        check_output("E line_done timing", 16'(done_idx), 16'(last_valid_idx + 1));
        check_output("E idle pix_valid", 16'(pix_valid), 16'h0);
        check_output("E idle ram_req", 16'(bus.ram_req), 16'h0);

        $display("[TB] async reset in LATCH, restart during REQ");
        ram_data_v = 8'h41;
        rom0_v     = 8'h00;
        rom1_v     = 8'hFF;
        apply_stimulus(8'h45, 1'b0);
        tick();
        check_output("F c2 rom_a", 16'(bus.rom_a), 16'h20D);
        tick();
        reset = 1'b0;
        #1;
        check_output("F async rom_a", 16'(bus.rom_a), 16'h0);
        check_output("F async ram_addr", 16'(bus.ram_addr), 16'h0);
        check_output("F async ram_req", 16'(bus.ram_req), 16'h0);
        check_output("F async pix_valid", 16'(pix_valid), 16'h0);
        #2;
        reset    = 1'b1;
        auto_ack = 1'b0;
        tick();
        apply_stimulus(8'h45, 1'b0);
        check_output("F c1 ram_addr", 16'(bus.ram_addr), 16'h100);
        apply_stimulus(8'h8B, 1'b0);
        check_output("F held ram_req", 16'(bus.ram_req), 16'h1);
        check_output("F held ram_addr", 16'(bus.ram_addr), 16'h100);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        check_output("F rerequest ram_req", 16'(bus.ram_req), 16'h1);
        check_output("F rerequest ram_addr", 16'(bus.ram_addr), 16'h220);
        check_output("F discarded rom_a", 16'(bus.rom_a), 16'h0);
        ram_data_v = 8'h22;
        man_ack    = 1'b1;
        tick();
        man_ack = 1'b0;
        check_output("F new rom_a", 16'(bus.rom_a), 16'h113);
        tick();
        tick();
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        check_output("F first pix", 16'(pix), 16'h2);
        check_output("F first valid", 16'(pix_valid), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
